// File: rtl/apb_regbank.sv
// APB3 slave register bank: N_WR read/write registers, N_RD read-only inputs,
// configurable wait states, PSLVERR decode, per-register write strobes, error counter.

module apb_regbank_reg #(
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [DWIDTH-1:0] d_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              stb_o
);
    logic [DWIDTH-1:0] reg_q;
    logic              stb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_q <= '0;
            stb_q <= 1'b0;
        end else begin
            stb_q <= we_i;
            if (we_i) reg_q <= d_i;
        end
    end

    assign q_o   = reg_q;
    assign stb_o = stb_q;
endmodule

module apb_regbank #(
    parameter int AWIDTH      = 4,
    parameter int DWIDTH      = 8,
    parameter int N_WR        = 5,
    parameter int N_RD        = 3,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [AWIDTH-1:0]      PADDR,
    input  logic [DWIDTH-1:0]      PWDATA,
    output logic [DWIDTH-1:0]      PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    input  logic [N_RD*DWIDTH-1:0] regr_in,
    output logic [N_WR*DWIDTH-1:0] regw_out,
    output logic [N_WR-1:0]        regw_stb,
    output logic [7:0]             err_cnt
);
    if (N_WR < 1 || N_WR > 2**AWIDTH - 1) begin : g_bad_nwr
        $error("apb_regbank: N_WR out of range");
    end
    if (N_RD < 1 || N_WR + N_RD > 2**AWIDTH) begin : g_bad_nrd
        $error("apb_regbank: N_WR+N_RD exceeds address space");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("apb_regbank: WAIT_CYCLES out of range");
    end

    typedef enum logic {IDLE, ACCESS} state_e;

    localparam logic [3:0]      WAIT_L = 4'(WAIT_CYCLES);
    localparam logic [AWIDTH:0] RW_END = (AWIDTH+1)'(N_WR);
    localparam logic [AWIDTH:0] RO_END = (AWIDTH+1)'(N_WR + N_RD);

    state_e                         state_q;
    logic [AWIDTH-1:0]              addr_q;
    logic                           wr_q;
    logic [DWIDTH-1:0]              wdata_q;
    logic [3:0]                     cnt_q;
    logic [7:0]                     err_q, err_d;
    logic [N_WR-1:0][DWIDTH-1:0]    reg_q;
    logic [N_WR-1:0]                we;

    logic [AWIDTH:0]   addr_x;
    logic              rw_hit, ro_hit, ready, slverr;
    logic [DWIDTH-1:0] rd_val;

    assign addr_x = {1'b0, addr_q};
    assign rw_hit = addr_x < RW_END;
    assign ro_hit = !rw_hit && (addr_x < RO_END);
    assign ready  = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
    assign slverr = ready && (wr_q ? !rw_hit : !(rw_hit || ro_hit));

    // Read mux works off the captured address; read-only inputs are live here.
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < N_WR; k++)
            if (addr_x == (AWIDTH+1)'(k)) rd_val = reg_q[k];
        for (int k = 0; k < N_RD; k++)
            if (addr_x == (AWIDTH+1)'(N_WR + k)) rd_val = regr_in[k*DWIDTH +: DWIDTH];
    end

    assign PREADY  = ready;
    assign PSLVERR = slverr;
    assign PRDATA  = (ready && !wr_q && !slverr) ? rd_val : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // PSEL&PENABLE without a preceding setup is ignored here.
                    if (PSEL && !PENABLE) begin
                        addr_q  <= PADDR;
                        wr_q    <= PWRITE;
                        wdata_q <= PWDATA;
                        cnt_q   <= WAIT_L;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state_q <= IDLE;
                    end else if (PENABLE) begin
                        if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                        else               state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign err_d = (slverr && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) err_q <= '0;
        else          err_q <= err_d;
    end

    for (genvar k = 0; k < N_WR; k++) begin : g_reg
        assign we[k] = ready && wr_q && (addr_x == (AWIDTH+1)'(k));
        apb_regbank_reg #(.DWIDTH(DWIDTH)) u_reg (
            .clk_i  (PCLK),
            .rst_ni (PRESETn),
            .we_i   (we[k]),
            .d_i    (wdata_q),
            .q_o    (reg_q[k]),
            .stb_o  (regw_stb[k])
        );
    end

    assign regw_out = reg_q;
    assign err_cnt  = err_q;
endmodule
